// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like memory port between instruction
// fetch and the data (load/store) requester. Data normally wins, a starvation
// counter gives fetch one grant after STARVE_LIM lost cycles, and an in-order
// source FIFO routes each response back to the requester that issued it.
module sram_bus_arbiter #(
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  lock_state_t          lock_q, lock_nxt;
  logic                 locked_src;
  logic [STV_W-1:0]     starve_cnt;
  logic [MAX_OUTST-1:0] src_fifo;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic grant, grant_vld, full, empty, accept, pop, head_src;

  // Pointer advance with wrap at MAX_OUTST (not a power of two in general).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant selection, request issue and acceptance, all combinational.
  always_comb begin
    grant = SRC_DATA;
    if (lock_q == LK_HELD)
      grant = locked_src;
    else if ((starve_cnt == STV_W'(STARVE_LIM)) && inst_req)
      grant = SRC_INST;
    else if (data_req)
      grant = SRC_DATA;
    else
      grant = SRC_INST;

    grant_vld = (grant == SRC_DATA) ? data_req : inst_req;
    full      = (count == CNT_W'(MAX_OUTST));
    empty     = (count == '0);
    mem_req   = grant_vld && !full && !reset;
    accept    = mem_req && mem_addr_ok;

    // A fetch is always a word read with no strobes or write data.
    if (grant == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = 1'b0;
      mem_size  = 2'd2;
      mem_wstrb = 4'h0;
      mem_addr  = inst_addr;
      mem_wdata = 32'h0;
    end

    inst_addr_ok = accept && (grant == SRC_INST);
    data_addr_ok = accept && (grant == SRC_DATA);
  end

  // Response routing: a response with nothing outstanding is dropped.
  always_comb begin
    head_src     = src_fifo[rd_ptr];
    pop          = mem_data_ok && !empty && !reset;
    inst_data_ok = pop && (head_src == SRC_INST);
    data_data_ok = pop && (head_src == SRC_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  // Lock state register: holds the grant while downstream stalls a request.
  always_ff @(posedge clk) begin
    if (reset) lock_q <= LK_FREE;
    else       lock_q <= lock_nxt;
  end

  // Lock next state: engage on an unaccepted request, release on acceptance.
  always_comb begin
    lock_nxt = lock_q;
    case (lock_q)
      LK_FREE: if (mem_req && !mem_addr_ok) lock_nxt = LK_HELD;
      LK_HELD: if (accept)                  lock_nxt = LK_FREE;
      default: lock_nxt = LK_FREE;
    endcase
  end

  // Remember which source was stalled so the grant cannot switch under it.
  always_ff @(posedge clk) begin
    if ((lock_q == LK_FREE) && mem_req && !mem_addr_ok)
      locked_src <= grant;
  end

  // Starvation counter: counts cycles a pending fetch is not accepted.
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (!inst_req || inst_addr_ok)
      starve_cnt <= '0;
    else if (starve_cnt != STV_W'(STARVE_LIM))
      starve_cnt <= starve_cnt + STV_W'(1);
  end

  // Source FIFO control: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Source FIFO storage: one bit per accepted transaction.
  always_ff @(posedge clk) begin
    if (accept) src_fifo[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a response scoreboard: the
// stimulus pushes the expected {source, rdata} at acceptance, a monitor pops
// and compares whenever either data_ok rises.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        src;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUTST(2), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic push_exp(input logic src, input logic [31:0] rdata);
    resp_t r;
    r.src   = src;
    r.rdata = rdata;
    sb.push_back(r);
  endtask

  task automatic chk_quiet(input string name);
    chk1({name, ".mem_req"},      mem_req,      1'b0);
    chk1({name, ".inst_addr_ok"}, inst_addr_ok, 1'b0);
    chk1({name, ".data_addr_ok"}, data_addr_ok, 1'b0);
    chk1({name, ".inst_data_ok"}, inst_data_ok, 1'b0);
    chk1({name, ".data_data_ok"}, data_data_ok, 1'b0);
  endtask

  // Idle inputs; data fields carry junk so fetch muxing is really exercised.
  task automatic idle();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b1;
    data_size   = 2'd0;
    data_wstrb  = 4'hF;
    data_addr   = 32'hFFFF_FFF0;
    data_wdata  = 32'hFFFF_FFFF;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  task automatic set_data(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                          input logic [31:0] wdata);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = 2'd2;
    data_wstrb = strb;
    data_addr  = addr;
    data_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT returns data.
  always @(negedge clk) begin
    resp_t e;
    if (inst_data_ok && data_data_ok) begin
      total_cnt++;
      $display("FAIL resp_both: inst_data_ok=1 and data_data_ok=1 together, expected at most one");
    end else if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL resp_unexpected: inst_data_ok=%b data_data_ok=%b, expected none outstanding",
                 inst_data_ok, data_data_ok);
      end else begin
        e = sb.pop_front();
        chk1("resp_src", data_data_ok, e.src);
        chk32("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    // Reset with every request input active.
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst");
      next_cycle();
    end
    reset = 1'b0;
    idle();

    // Single fetch: accept in cycle 0, data in cycle 2.
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk1("s1.mem_req", mem_req, 1'b1);
    chk32("s1.mem_addr", mem_addr, 32'h1C00_0000);
    chk1("s1.mem_wr", mem_wr, 1'b0);
    chk32("s1.mem_size", 32'(mem_size), 32'd2);
    chk32("s1.mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk32("s1.mem_wdata", mem_wdata, 32'h0);
    chk1("s1.inst_addr_ok", inst_addr_ok, 1'b1);
    chk1("s1.data_addr_ok", data_addr_ok, 1'b0);
    push_exp(1'b0, 32'h0280_0C0C);
    next_cycle(); idle();
    @(negedge clk);
    chk1("s1.c1_inst_data_ok", inst_data_ok, 1'b0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
    @(negedge clk);
    chk1("s1.c2_inst_data_ok", inst_data_ok, 1'b1);
    chk1("s1.c2_data_data_ok", data_data_ok, 1'b0);
    next_cycle(); idle();

    // Contention: data store wins, fetch follows, responses data then inst.
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    set_data(1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF);
    data_size = 2'd1;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk1("s2.data_addr_ok", data_addr_ok, 1'b1);
    chk1("s2.inst_addr_ok0", inst_addr_ok, 1'b0);
    chk32("s2.mem_wstrb", 32'(mem_wstrb), 32'h3);
    chk32("s2.mem_addr0", mem_addr, 32'h0000_0100);
    chk32("s2.mem_size0", 32'(mem_size), 32'd1);
    chk32("s2.mem_wdata0", mem_wdata, 32'hDEAD_BEEF);
    push_exp(1'b1, 32'h0);
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    chk1("s2.inst_addr_ok1", inst_addr_ok, 1'b1);
    chk32("s2.mem_addr1", mem_addr, 32'h1C00_0004);
    chk32("s2.mem_wstrb1", 32'(mem_wstrb), 32'h0);
    push_exp(1'b0, 32'h1111_1111);
    next_cycle(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    next_cycle(); idle();

    // Lock hold on a stalled store while fetch rises.
    set_data(1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D);
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) begin inst_req = 1'b1; inst_addr = 32'h1C00_0008; end
      @(negedge clk);
      chk1($sformatf("s3.c%0d_mem_req", c), mem_req, 1'b1);
      chk32($sformatf("s3.c%0d_mem_addr", c), mem_addr, 32'h0000_0100);
      chk1($sformatf("s3.c%0d_mem_wr", c), mem_wr, 1'b1);
      chk1($sformatf("s3.c%0d_addr_ok", c), data_addr_ok | inst_addr_ok, 1'b0);
      next_cycle();
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk1("s3.data_accept", data_addr_ok, 1'b1);
    push_exp(1'b1, 32'h0);
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    chk1("s3.inst_accept", inst_addr_ok, 1'b1);
    chk32("s3.inst_addr", mem_addr, 32'h1C00_0008);
    push_exp(1'b0, 32'h2222_2222);
    next_cycle(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    next_cycle(); idle();

    // Lock on a stalled fetch: a later data request must not steal the grant.
    inst_req = 1'b1; inst_addr = 32'h1C00_000C;
    @(negedge clk);
    chk32("s3b.mem_addr0", mem_addr, 32'h1C00_000C);
    next_cycle();
    set_data(1'b0, 4'h0, 32'h0000_0200, 32'h0);
    @(negedge clk);
    chk32("s3b.mem_addr1", mem_addr, 32'h1C00_000C);
    chk1("s3b.mem_wr1", mem_wr, 1'b0);
    chk1("s3b.data_addr_ok1", data_addr_ok, 1'b0);
    next_cycle();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk1("s3b.inst_accept", inst_addr_ok, 1'b1);
    chk1("s3b.data_addr_ok2", data_addr_ok, 1'b0);
    push_exp(1'b0, 32'h3333_3333);
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    chk1("s3b.data_accept", data_addr_ok, 1'b1);
    chk32("s3b.mem_addr3", mem_addr, 32'h0000_0200);
    push_exp(1'b1, 32'h4444_4444);
    next_cycle(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h3333_3333;
    @(negedge clk);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h4444_4444;
    @(negedge clk);
    next_cycle(); idle();

    // Full: two loads outstanding block a third, even across a pop.
    set_data(1'b0, 4'h0, 32'h0000_0300, 32'h0);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk1("s4.accept0", data_addr_ok, 1'b1);
    push_exp(1'b1, 32'h5555_5555);
    next_cycle();
    data_addr = 32'h0000_0304;
    @(negedge clk);
    chk1("s4.accept1", data_addr_ok, 1'b1);
    push_exp(1'b1, 32'h6666_6666);
    next_cycle();
    data_addr = 32'h0000_0308;
    @(negedge clk);
    chk1("s4.full_mem_req", mem_req, 1'b0);
    chk1("s4.full_addr_ok", data_addr_ok, 1'b0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk1("s4.pop_cycle_mem_req", mem_req, 1'b0);
    chk1("s4.pop_cycle_addr_ok", data_addr_ok, 1'b0);
    next_cycle();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk1("s4.after_pop_mem_req", mem_req, 1'b1);
    chk1("s4.after_pop_addr_ok", data_addr_ok, 1'b1);
    chk32("s4.after_pop_addr", mem_addr, 32'h0000_0308);
    push_exp(1'b1, 32'h7777_7777);
    next_cycle(); idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h6666_6666;
    @(negedge clk);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    next_cycle(); idle();

    // Starvation: continuous data traffic, fetch wins on its 5th pending cycle.
    inst_req = 1'b1; inst_addr = 32'h1C00_0010;
    mem_addr_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_data(1'b0, 4'h0, 32'h0000_0400 + 32'(4 * k), 32'h0);
      mem_data_ok = (k > 0);
      mem_rdata   = (k == 5) ? 32'hB000_0004 : 32'hA000_0000 + 32'(k - 1);
      @(negedge clk);
      if (k == 4) begin
        chk1("s5.k4_inst_addr_ok", inst_addr_ok, 1'b1);
        chk1("s5.k4_data_addr_ok", data_addr_ok, 1'b0);
        chk32("s5.k4_mem_addr", mem_addr, 32'h1C00_0010);
        push_exp(1'b0, 32'hB000_0004);
      end else begin
        chk1($sformatf("s5.k%0d_data_addr_ok", k), data_addr_ok, 1'b1);
        chk1($sformatf("s5.k%0d_inst_addr_ok", k), inst_addr_ok, 1'b0);
        push_exp(1'b1, 32'hA000_0000 + 32'(k));
      end
      next_cycle();
    end
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'hA000_0005;
    @(negedge clk);
    next_cycle(); idle();

    // Reset with two transactions outstanding, then stray responses.
    set_data(1'b0, 4'h0, 32'h0000_0500, 32'h0);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk1("s6.accept0", data_addr_ok, 1'b1);
    push_exp(1'b1, 32'h8888_8888);
    next_cycle();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0014;
    @(negedge clk);
    chk1("s6.accept1", inst_addr_ok, 1'b1);
    push_exp(1'b0, 32'h9999_9999);
    next_cycle();
    reset = 1'b1;
    data_req = 1'b1; inst_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    mem_rdata = 32'h8888_8888;
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_quiet($sformatf("s6.rst%0d", c));
      next_cycle();
    end
    reset = 1'b0;
    idle();
    for (int c = 0; c < 2; c++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'h9999_9999;
      @(negedge clk);
      chk1($sformatf("s6.stray%0d_inst_data_ok", c), inst_data_ok, 1'b0);
      chk1($sformatf("s6.stray%0d_data_data_ok", c), data_data_ok, 1'b0);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk32("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares a single sram-like memory port between the instruction-fetch requester and the data requester (EXE-stage load/store).
- Uses the req/addr_ok/data_ok handshake on all three ports.
- Grants one request per cycle, with data priority and an anti-starvation counter for fetch.
- Tracks up to MAX_OUTST accepted transactions in an in-order source FIFO so each data_ok/rdata is routed back to the requester that issued it.

Parameters:
- MAX_OUTST, 2: maximum accepted-but-unanswered transactions (1..4).
- STARVE_LIM, 4: consecutive cycles a pending inst_req may lose arbitration before it gets priority for one grant.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address (read only, size fixed 2'd2)
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch read data valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store done
- data_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes (4'h0 for fetch)
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data (0 for fetch)
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data

Behaviour:
- **Reset:**
  - FIFO empty, starve_cnt = 0, lock = 0.
  - mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok are all forced 0 while reset = 1.
- **Grant selection (combinational):**
  - If lock = 1, the grant is held at locked_src.
  - Otherwise, if starve_cnt == STARVE_LIM and inst_req = 1, grant fetch.
  - Otherwise, if data_req = 1, grant data; else if inst_req = 1, grant fetch.
- **Request issue:**
  - mem_req = granted request valid && !full.
  - The mem_* fields mux from the granted source.
  - A fetch drives mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
- **Acceptance:**
  - The granted source's addr_ok = mem_req && mem_addr_ok; the other addr_ok = 0.
  - Zero-cycle latency from mem_addr_ok to the requester's addr_ok.
- **Lock:**
  - lock is set when mem_req = 1 && mem_addr_ok = 0; it latches locked_src = the current grant.
  - lock is cleared on the cycle mem_req && mem_addr_ok.
  - While locked, the grant never switches, so downstream sees stable request fields.
- **Source FIFO:** MAX_OUTST entries of 1 bit (0 = inst, 1 = data), with read/write pointers and a count.
  - Push of the grant on mem_req && mem_addr_ok.
  - Pop on mem_data_ok.
  - full = (count == MAX_OUTST). Full blocks mem_req even when a pop occurs in the same cycle.
  - Simultaneous push and pop is legal when not full: count is unchanged and both pointers advance.
  - Pointers wrap modulo MAX_OUTST.
- **Response routing:**
  - On mem_data_ok with a non-empty FIFO, raise the head source's data_ok for exactly that cycle; the other data_ok stays 0.
  - inst_rdata = data_rdata = mem_rdata.
  - mem_data_ok while empty is a protocol error: it is ignored, there is no pop, and both data_ok stay 0.
- **Starvation counter:**
  - Increments (saturating at STARVE_LIM) each cycle inst_req = 1 and fetch is not accepted.
  - Clears to 0 on fetch acceptance or when inst_req = 0.
- **Ordering:** responses are strictly in acceptance order; no reordering, no cancellation.
- **Reset mid-transaction:** FIFO contents are discarded; any later mem_data_ok falls into the empty case.

Test Plan:
- **Single fetch:** inst_req = 1, addr 0x1C000000; mem_addr_ok = 1 the same cycle; mem_data_ok 2 cycles later with rdata 0x02800C0C.
  - Required: inst_addr_ok in cycle 0; inst_data_ok = 1 in cycle 2 with inst_rdata 0x02800C0C; data_data_ok = 0 throughout.
- **Contention:** inst_req and data_req (store, wstrb 4'h3, addr 0x100) both asserted.
  - Required: data granted first with mem_wstrb = 4'h3; fetch granted the next cycle; responses returned data then inst.
- **Lock hold:** data_req issued with mem_addr_ok = 0 for 3 cycles, and inst_req rises in cycle 1.
  - Required: mem_addr stays 0x100 and mem_wr stays 1 for all 3 cycles; no grant switch until acceptance.
- **Full:** MAX_OUTST = 2, two accepted loads with no mem_data_ok.
  - Required: mem_req = 0 while a third request is pending. A mem_data_ok in cycle N pops the FIFO; mem_req reasserts in cycle N+1, not N.
- **Starvation:** data_req held at 1 continuously and inst_req = 1, STARVE_LIM = 4.
  - Required: fetch accepted on the 5th pending cycle; starve_cnt returns to 0; data regains priority afterwards.
- **Reset and stray response:**
  - Reset asserted with 2 transactions outstanding; then mem_data_ok pulses.
  - Required: all outputs 0 during reset; after reset neither inst_data_ok nor data_data_ok rises.
